// File: rtl/color_sequence_player.sv
// Stores up to DEPTH 4-bit color codes and plays them back on an RGB LED,
// each shown for ON_CYCLES clocks followed by a GAP_CYCLES dark interval.
module color_sequence_player #(
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 50_000_000,
  parameter int GAP_CYCLES = 12_500_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [3:0]                 wr_color,
  input  logic                       clear,
  input  logic                       play,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [3:0]                 cur_color,
  output logic [2:0]                 led_rgb,
  output logic                       done
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      cur_color_q, cur_color_d;
  logic [2:0]      led_q, led_d;
  logic            busy_q, busy_d;
  logic            full_q, full_d;
  logic            done_q, done_d;
  logic            mem_we;
  logic [IW-1:0]   rd_idx;
  logic [3:0]      rd_color;
  logic            last_entry;
  logic [3:0]      color_mem [DEPTH];

  function automatic logic [2:0] code_to_rgb(input logic [3:0] c);
    case (c)
      4'd2:    code_to_rgb = 3'b100;
      4'd3:    code_to_rgb = 3'b011;
      4'd4:    code_to_rgb = 3'b110;
      4'd5:    code_to_rgb = 3'b101;
      default: code_to_rgb = 3'b000;
    endcase
  endfunction

  // The next color is fetched as the state enters ON, so the output flop
  // itself acts as the registered read of the storage array.
  assign rd_idx     = (state_q == ST_GAP) ? idx_q + IW'(1) : '0;
  assign rd_color   = color_mem[rd_idx];
  assign last_entry = ({1'b0, idx_q} == count_q - CW'(1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    cur_color_d = cur_color_q;
    led_d       = led_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    if (clear) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      idx_d       = '0;
      timer_d     = '0;
      cur_color_d = 4'd0;
      led_d       = 3'b000;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play) begin
            if (count_q != '0) begin
              state_d     = ST_ON;
              idx_d       = '0;
              timer_d     = ON_LOAD;
              cur_color_d = rd_color;
              led_d       = code_to_rgb(rd_color);
              busy_d      = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end else if (wr_en && !full_q && (wr_color inside {[4'd2:4'd5]})) begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        ST_ON: begin
          if (timer_q == '0) begin
            state_d     = ST_GAP;
            timer_d     = GAP_LOAD;
            cur_color_d = 4'd0;
            led_d       = 3'b000;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (last_entry) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_ON;
            idx_d       = rd_idx;
            timer_d     = ON_LOAD;
            cur_color_d = rd_color;
            led_d       = code_to_rgb(rd_color);
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      cur_color_q <= 4'd0;
      led_q       <= 3'b000;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      cur_color_q <= cur_color_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      done_q      <= done_d;
    end
  end

  // Storage has no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) color_mem[count_q[IW-1:0]] <= wr_color;
  end

  assign busy      = busy_q;
  assign full      = full_q;
  assign count     = count_q;
  assign cur_color = cur_color_q;
  assign led_rgb   = led_q;
  assign done      = done_q;
endmodule
